// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   fetch_state_t    : IDLE (waiting for trigger) / RUN (fetching)
//   INSTR_BYTES      : byte stride between consecutive instructions
//   DEFAULT_RESET_PC : default first fetch address after reset
package fetch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO holding {pc, instr} pairs returned by the
// instruction memory until decode accepts them.
//   clk, rst   : clock, synchronous active-high reset (empties the queue)
//   push       : write push_data at the tail
//   pop        : drop the head entry (ignored when empty)
//   flush      : empty the queue; overrides push and pop
//   push_data  : entry to write
//   head_data  : current head entry (meaningful when !empty)
//   full/empty : occupancy flags
//   count      : number of held entries (0..2)
module fetch_fifo #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  full,
  output logic                  empty,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] entry_reg [2];
  logic                  head_reg;
  logic                  tail_reg;
  logic [1:0]            count_reg;
  logic                  do_push;
  logic                  do_pop;

  assign empty     = (count_reg == 2'd0);
  assign full      = (count_reg == 2'd2);
  assign count     = count_reg;
  assign head_data = entry_reg[head_reg];

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && !empty;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_reg  <= 1'b0;
      tail_reg  <= 1'b0;
      count_reg <= 2'd0;
    end else begin
      if (do_push) begin
        entry_reg[tail_reg] <= push_data;
        tail_reg            <= ~tail_reg;
      end
      if (do_pop) begin
        head_reg <= ~head_reg;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // The issue rule upstream keeps occupancy within two entries.
  a_count_bound : assert property (@(posedge clk) disable iff (rst) count_reg <= 2'd2);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end feeding the decode pipeline register.
// Owns the fetch PC, issues reads to a 1-cycle-latency synchronous
// instruction memory, and buffers returned words in a 2-entry queue so
// decode stalls never lose data. Taken branches/jumps redirect the PC and
// flush everything younger.
//   clk, rst       : clock, synchronous active-high reset (-> IDLE)
//   trigger_i      : start fetching (sampled in IDLE)
//   imem_req_o     : read request this cycle
//   imem_addr_o    : read address
//   imem_rdata_i   : read data, valid the cycle after a request
//   redirect_i     : taken branch/jump from execute
//   redirect_pc_i  : redirect target
//   stall_i        : decode cannot accept the head entry
//   valid_o        : head entry valid
//   instr_o        : head instruction
//   pc_o           : head PC
//   pc_plus4_o     : head PC + 4
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    PC_WIDTH          = 32,
  parameter int                    INSTRUCTION_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC          = PC_WIDTH'(DEFAULT_RESET_PC),
  parameter int                    BUF_DEPTH         = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         trigger_i,
  output logic                         imem_req_o,
  output logic [PC_WIDTH-1:0]          imem_addr_o,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_rdata_i,
  input  logic                         redirect_i,
  input  logic [PC_WIDTH-1:0]          redirect_pc_i,
  input  logic                         stall_i,
  output logic                         valid_o,
  output logic [INSTRUCTION_WIDTH-1:0] instr_o,
  output logic [PC_WIDTH-1:0]          pc_o,
  output logic [PC_WIDTH-1:0]          pc_plus4_o
);

  localparam int ENTRY_WIDTH = PC_WIDTH + INSTRUCTION_WIDTH;

  fetch_state_t          state_reg, state_next;
  logic [PC_WIDTH-1:0]   fetch_pc_reg, fetch_pc_next;
  logic [PC_WIDTH-1:0]   issued_pc_reg, issued_pc_next;
  logic                  inflight_reg, inflight_next;

  logic                  issue;
  logic                  pop;
  logic                  push;
  logic [2:0]            occupancy;
  logic [ENTRY_WIDTH-1:0] head_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [1:0]            fifo_count;
  logic [PC_WIDTH-1:0]   head_pc;
  logic [INSTRUCTION_WIDTH-1:0] head_instr;

  assign head_pc    = head_data[ENTRY_WIDTH-1 -: PC_WIDTH];
  assign head_instr = head_data[INSTRUCTION_WIDTH-1:0];

  assign valid_o    = !fifo_empty;
  assign pop        = valid_o && !stall_i;
  // A response is only kept if no redirect squashes it this cycle.
  assign push       = inflight_reg && !redirect_i;

  // Slots committed after this edge: held entries plus the outstanding
  // response, minus the entry leaving this cycle. Combinational on stall_i
  // so a full pipeline keeps one request per cycle while decode drains.
  assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight_reg} - {2'b00, pop};

  assign instr_o    = valid_o ? head_instr : '0;
  assign pc_o       = valid_o ? head_pc : '0;
  assign pc_plus4_o = valid_o ? (head_pc + PC_WIDTH'(INSTR_BYTES)) : '0;

  assign imem_req_o  = issue;
  assign imem_addr_o = fetch_pc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      fetch_pc_reg  <= RESET_PC;
      issued_pc_reg <= '0;
      inflight_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      fetch_pc_reg  <= fetch_pc_next;
      issued_pc_reg <= issued_pc_next;
      inflight_reg  <= inflight_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    fetch_pc_next  = fetch_pc_reg;
    issued_pc_next = issued_pc_reg;
    inflight_next  = 1'b0;
    issue          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (trigger_i) begin
          state_next = RUN;
        end
      end
      RUN: begin
        issue = !redirect_i && (occupancy < 3'(BUF_DEPTH));
      end
      default: state_next = IDLE;
    endcase

    if (redirect_i) begin
      // Targets are word aligned; low address bits are dropped.
      fetch_pc_next = {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
      inflight_next = 1'b0;
    end else if (issue) begin
      fetch_pc_next  = fetch_pc_reg + PC_WIDTH'(INSTR_BYTES);
      issued_pc_next = fetch_pc_reg;
      inflight_next  = 1'b1;
    end
  end

  fetch_fifo #(
    .DATA_WIDTH(ENTRY_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_i),
    .push_data ({issued_pc_reg, imem_rdata_i}),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(fifo_full && push && !pop));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        trigger_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  // Memory model: 1-cycle latency, data = addr ^ KEY; junk when no request.
  always @(posedge clk) begin
    imem_rdata_i <= imem_req_o ? (imem_addr_o ^ KEY) : 32'hDEAD_BEEF;
  end

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .trigger_i     (trigger_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .stall_i       (stall_i),
    .valid_o       (valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o)
  );

  task automatic set_inputs(input logic t, input logic s, input logic r, input logic [31:0] rpc);
    @(negedge clk);
    trigger_i     = t;
    stall_i       = s;
    redirect_i    = r;
    redirect_pc_i = rpc;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; trigger_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (valid_o !== 1'b0 || imem_req_o !== 1'b0 || instr_o !== 32'h0 || pc_o !== 32'h0 || pc_plus4_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b req=%b instr=%h pc=%h pc4=%h required all zero",
               valid_o, imem_req_o, instr_o, pc_o, pc_plus4_o);
    end
    for (int i = 0; i < 10; i++) begin
      set_inputs(1'b0, 1'b0, 1'b0, 32'h0);
      vectors++;
      if (valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_quiet[%0d]: valid=%b req=%b required 0 0", i, valid_o, imem_req_o);
      end
    end
  endtask

  // Cycle t: trigger; t+1, t+2: requests at 0x0, 0x4; first delivery at t+3.
  task automatic test_trigger();
    set_inputs(1'b1, 1'b0, 1'b0, 32'h0);
    vectors++;
    if (imem_req_o !== 1'b0 || valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL trigger_t0: req=%b valid=%b required 0 0", imem_req_o, valid_o);
    end
    set_inputs(1'b0, 1'b0, 1'b0, 32'h0);
    vectors++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL trigger_t1: req=%b addr=%h valid=%b required 1 00000000 0", imem_req_o, imem_addr_o, valid_o);
    end
    set_inputs(1'b0, 1'b0, 1'b0, 32'h0);
    vectors++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4 || valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL trigger_t2: req=%b addr=%h valid=%b required 1 00000004 0", imem_req_o, imem_addr_o, valid_o);
    end
    exp_pc = 32'h0;
  endtask

  // Steady state: one delivery per cycle, request running two words ahead.
  task automatic test_free_run(input int n);
    for (int i = 0; i < n; i++) begin
      set_inputs(1'b0, 1'b0, 1'b0, 32'h0);
      vectors++;
      if (valid_o !== 1'b1 || pc_o !== exp_pc || instr_o !== (exp_pc ^ KEY) || pc_plus4_o !== exp_pc + 32'd4) begin
        miscompares++;
        $display("FAIL free_run_out: valid=%b pc=%h instr=%h pc4=%h required 1 %h %h %h",
                 valid_o, pc_o, instr_o, pc_plus4_o, exp_pc, exp_pc ^ KEY, exp_pc + 32'd4);
      end
      vectors++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== exp_pc + 32'd8) begin
        miscompares++;
        $display("FAIL free_run_req: req=%b addr=%h required 1 %h", imem_req_o, imem_addr_o, exp_pc + 32'd8);
      end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  // Head held stable under stall; requests stop immediately (1 held + 1 in flight).
  task automatic test_stall(input int n);
    for (int i = 0; i < n; i++) begin
      set_inputs(1'b0, 1'b1, 1'b0, 32'h0);
      vectors++;
      if (valid_o !== 1'b1 || pc_o !== exp_pc || instr_o !== (exp_pc ^ KEY) || pc_plus4_o !== exp_pc + 32'd4 || imem_req_o !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: valid=%b pc=%h instr=%h pc4=%h req=%b required 1 %h %h %h 0",
                 i, valid_o, pc_o, instr_o, pc_plus4_o, imem_req_o, exp_pc, exp_pc ^ KEY, exp_pc + 32'd4);
      end
    end
  endtask

  // Redirect with stall asserted; expects flush and restart at aligned target.
  task automatic test_redirect(input logic [31:0] target, input logic [31:0] aligned);
    set_inputs(1'b0, 1'b1, 1'b1, target);
    vectors++;
    if (imem_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL redirect_req_off: req=%b required 0", imem_req_o);
    end
    set_inputs(1'b0, 1'b0, 1'b0, 32'h0);
    vectors++;
    if (valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== aligned) begin
      miscompares++;
      $display("FAIL redirect_r1: valid=%b req=%b addr=%h required 0 1 %h", valid_o, imem_req_o, imem_addr_o, aligned);
    end
    set_inputs(1'b0, 1'b0, 1'b0, 32'h0);
    vectors++;
    if (valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== aligned + 32'd4) begin
      miscompares++;
      $display("FAIL redirect_r2: valid=%b req=%b addr=%h required 0 1 %h", valid_o, imem_req_o, imem_addr_o, aligned + 32'd4);
    end
    exp_pc = aligned;
  endtask

  // Reset while one entry is held and one response is in flight.
  task automatic test_reset_mid();
    test_stall(1);
    @(negedge clk);
    rst = 1'b1; stall_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid[%0d]: valid=%b req=%b required 0 0", i, valid_o, imem_req_o);
      end
      set_inputs(1'b0, 1'b0, 1'b0, 32'h0);
    end
  endtask

  initial begin
    test_reset();
    test_trigger();
    test_free_run(8);
    test_stall(5);
    test_free_run(6);
    test_redirect(32'h0000_0100, 32'h0000_0100);
    test_free_run(4);
    test_stall(2);
    test_redirect(32'h0000_0103, 32'h0000_0100);
    test_free_run(3);
    test_redirect(32'hFFFF_FFFC, 32'hFFFF_FFFC);
    test_free_run(3);
    test_reset_mid();
    test_trigger();
    test_free_run(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
